// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: conditional-execution controller with NZCV flag register
// and an IT-style predicated block sequencer (IDLE/BLOCK FSM).
module cond_exec_ctrl #(
  parameter int IT_MAX_LEN = 4,
  parameter int NV_EXEC    = 0,
  localparam int LW        = $clog2(IT_MAX_LEN + 1)
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  instr_valid_in,
  input  logic [3:0]            instr_cond_in,
  input  logic                  flag_update_in,
  input  logic [3:0]            flag_result_in,
  input  logic                  flag_load_in,
  input  logic [3:0]            flag_load_data_in,
  input  logic                  it_start_in,
  input  logic [3:0]            it_cond_in,
  input  logic [IT_MAX_LEN-2:0] it_mask_in,
  input  logic [LW-1:0]         it_len_in,
  input  logic                  flush_in,
  output logic                  exec_valid_out,
  output logic                  exec_out,
  output logic [3:0]            flag_register_out,
  output logic                  it_active_out,
  output logic [LW-1:0]         it_remaining_out
);

  localparam logic [LW-1:0] MAX_LEN = LW'(IT_MAX_LEN);
  localparam logic [3:0]    COND_AL = 4'b1110;

  typedef enum logic {IDLE, BLOCK} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         remaining_q, remaining_d;
  logic [LW-1:0]         slot_idx_q, slot_idx_d;
  logic [3:0]            it_cond_q, it_cond_d;
  logic [IT_MAX_LEN-2:0] it_mask_q, it_mask_d;
  logic [3:0]            flags_q, flags_d;
  logic                  exec_valid_q, exec_valid_d;
  logic                  exec_q, exec_d;

  logic [3:0]            eff_cond;
  logic                  then_bit;
  logic                  never_exec;
  logic                  opening;
  logic                  executed;

  // Condition code evaluation against an NZCV value.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = (NV_EXEC != 0);
    endcase
  endfunction

  // Pick the condition in force this cycle and decide whether the instruction executes.
  always_comb begin
    eff_cond   = instr_cond_in;
    then_bit   = 1'b1;
    never_exec = 1'b0;
    opening    = 1'b0;
    for (int k = 1; k < IT_MAX_LEN; k++) begin
      if (slot_idx_q == LW'(k)) then_bit = it_mask_q[k-1];
    end
    if (state_q == BLOCK) begin
      if (slot_idx_q == '0 || then_bit) begin
        eff_cond = it_cond_q;
      end else begin
        eff_cond   = {it_cond_q[3:1], ~it_cond_q[0]};
        never_exec = (it_cond_q == COND_AL);
      end
    end else begin
      opening = instr_valid_in && it_start_in && (it_len_in != '0);
    end
    executed     = instr_valid_in && !flush_in &&
                   (opening || (!never_exec && cond_pass(eff_cond, flags_q)));
    exec_valid_d = instr_valid_in && !flush_in;
    exec_d       = executed;
  end

  // Next-state for the block sequencer and the flag register.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    slot_idx_d  = slot_idx_q;
    it_cond_d   = it_cond_q;
    it_mask_d   = it_mask_q;
    flags_d     = flags_q;

    if (flag_load_in) begin
      flags_d = flag_load_data_in;
    end else if (executed && flag_update_in && !opening) begin
      flags_d = flag_result_in;
    end

    if (flush_in) begin
      state_d     = IDLE;
      remaining_d = '0;
      slot_idx_d  = '0;
    end else if (instr_valid_in) begin
      if (state_q == BLOCK) begin
        slot_idx_d  = slot_idx_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == LW'(1)) state_d = IDLE;
      end else if (opening) begin
        state_d     = BLOCK;
        remaining_d = (it_len_in > MAX_LEN) ? MAX_LEN : it_len_in;
        slot_idx_d  = '0;
        it_cond_d   = it_cond_in;
        it_mask_d   = it_mask_in;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      slot_idx_q   <= '0;
      it_cond_q    <= '0;
      it_mask_q    <= '0;
      flags_q      <= '0;
      exec_valid_q <= 1'b0;
      exec_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      slot_idx_q   <= slot_idx_d;
      it_cond_q    <= it_cond_d;
      it_mask_q    <= it_mask_d;
      flags_q      <= flags_d;
      exec_valid_q <= exec_valid_d;
      exec_q       <= exec_d;
    end
  end

  assign exec_valid_out    = exec_valid_q;
  assign exec_out          = exec_q;
  assign flag_register_out = flags_q;
  assign it_active_out     = (state_q == BLOCK);
  assign it_remaining_out  = remaining_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Testbench for cond_exec_ctrl: two instances (NV_EXEC 0 and 1) driven in
// lockstep and compared every cycle against a queue-based reference model.
module tb_cond_exec_ctrl;

  logic       clk;
  logic       rst;
  logic       instrValid;
  logic [3:0] instrCond;
  logic       flagUpdate;
  logic [3:0] flagResult;
  logic       flagLoad;
  logic [3:0] flagLoadData;
  logic       itStart;
  logic [3:0] itCond;
  logic [2:0] itMask;
  logic [2:0] itLen;
  logic       flush;

  logic       ev0, ex0, act0, ev1, ex1, act1;
  logic [3:0] fl0, fl1;
  logic [2:0] rem0, rem1;

  int checks = 0;
  int errors = 0;

  // Reference model state: per-instance flags and registered outputs, and a
  // shared queue of pending block slots ({never, cond}).
  logic [3:0] mFlags [2];
  logic [1:0] mValid;
  logic [1:0] mExec;
  logic [4:0] mSlots [$];
  bit         lastReset;

  cond_exec_ctrl #(.IT_MAX_LEN(4), .NV_EXEC(0)) dut0 (
    .clk_in(clk), .reset_in(rst), .instr_valid_in(instrValid),
    .instr_cond_in(instrCond), .flag_update_in(flagUpdate),
    .flag_result_in(flagResult), .flag_load_in(flagLoad),
    .flag_load_data_in(flagLoadData), .it_start_in(itStart),
    .it_cond_in(itCond), .it_mask_in(itMask), .it_len_in(itLen),
    .flush_in(flush), .exec_valid_out(ev0), .exec_out(ex0),
    .flag_register_out(fl0), .it_active_out(act0), .it_remaining_out(rem0)
  );

  cond_exec_ctrl #(.IT_MAX_LEN(4), .NV_EXEC(1)) dut1 (
    .clk_in(clk), .reset_in(rst), .instr_valid_in(instrValid),
    .instr_cond_in(instrCond), .flag_update_in(flagUpdate),
    .flag_result_in(flagResult), .flag_load_in(flagLoad),
    .flag_load_data_in(flagLoadData), .it_start_in(itStart),
    .it_cond_in(itCond), .it_mask_in(itMask), .it_len_in(itLen),
    .flush_in(flush), .exec_valid_out(ev1), .exec_out(ex1),
    .flag_register_out(fl1), .it_active_out(act1), .it_remaining_out(rem1)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition rule: even codes test a base predicate, odd codes its inverse.
  function automatic logic modelCond(input logic [3:0] c, input logic [3:0] f, input int nv);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'b1110) return 1'b1;
    if (c == 4'b1111) return (nv != 0);
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic checkVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("exec_valid0", {3'b0, ev0}, {3'b0, mValid[0]});
    checkVal("exec_valid1", {3'b0, ev1}, {3'b0, mValid[1]});
    checkVal("flags0", fl0, mFlags[0]);
    checkVal("flags1", fl1, mFlags[1]);
    checkVal("it_active0", {3'b0, act0}, {3'b0, mSlots.size() > 0});
    checkVal("it_active1", {3'b0, act1}, {3'b0, mSlots.size() > 0});
    checkVal("remaining0", {1'b0, rem0}, 4'(mSlots.size()));
    checkVal("remaining1", {1'b0, rem1}, 4'(mSlots.size()));
    if (mValid[0] || lastReset) checkVal("exec0", {3'b0, ex0}, {3'b0, mExec[0]});
    if (mValid[1] || lastReset) checkVal("exec1", {3'b0, ex1}, {3'b0, mExec[1]});
  endtask

  task automatic clearInputs();
    rst = 0; instrValid = 0; instrCond = 0; flagUpdate = 0; flagResult = 0;
    flagLoad = 0; flagLoadData = 0; itStart = 0; itCond = 0; itMask = 0;
    itLen = 0; flush = 0;
  endtask

  // Advance the model by one cycle on the current inputs, clock, then compare.
  task automatic applyStimulus();
    bit         inBlock, opening;
    logic [4:0] code;
    logic       pass, ex;
    int         lenEff;
    inBlock = (mSlots.size() > 0);
    opening = !inBlock && instrValid && itStart && (itLen != 0);
    code    = inBlock ? mSlots[0] : {1'b0, instrCond};
    for (int n = 0; n < 2; n++) begin
      pass = opening ? 1'b1 : (code[4] ? 1'b0 : modelCond(code[3:0], mFlags[n], n));
      ex   = instrValid && !flush && pass;
      if (rst) begin
        mFlags[n] = 4'b0; mValid[n] = 1'b0; mExec[n] = 1'b0;
      end else begin
        mValid[n] = instrValid && !flush;
        mExec[n]  = ex;
        if (flagLoad) mFlags[n] = flagLoadData;
        else if (ex && flagUpdate && !opening) mFlags[n] = flagResult;
      end
    end
    if (rst || flush) begin
      mSlots.delete();
    end else if (instrValid) begin
      if (inBlock) begin
        void'(mSlots.pop_front());
      end else if (opening) begin
        lenEff = (itLen > 4) ? 4 : int'(itLen);
        for (int k = 0; k < lenEff; k++) begin
          if (k == 0 || itMask[k-1]) mSlots.push_back({1'b0, itCond});
          else if (itCond == 4'b1110) mSlots.push_back(5'h10);
          else mSlots.push_back({1'b0, itCond ^ 4'b0001});
        end
      end
    end
    lastReset = rst;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic loadFlags(input logic [3:0] f);
    clearInputs();
    flagLoad = 1; flagLoadData = f;
    applyStimulus();
  endtask

  initial begin
    logic [3:0] c4;
    clearInputs();
    rst = 1;
    applyStimulus();
    checkVal("reset_flags", fl0, 4'b0000);
    checkVal("reset_valid", {3'b0, ev0}, 4'b0);

    // Z set: EQ executes, NE does not.
    loadFlags(4'b0100);
    clearInputs(); instrValid = 1; instrCond = 4'b0000; applyStimulus();
    checkVal("eq_exec", {3'b0, ex0}, 4'b1);
    clearInputs(); instrValid = 1; instrCond = 4'b0001; applyStimulus();
    checkVal("ne_exec", {3'b0, ex0}, 4'b0);

    // N=1, Z=0, V=0 across all sixteen condition codes.
    loadFlags(4'b1000);
    for (int c = 0; c < 16; c++) begin
      clearInputs(); instrValid = 1; c4 = 4'(c); instrCond = c4; applyStimulus();
      case (c)
        10: checkVal("ge_exec", {3'b0, ex0}, 4'b0);
        11: checkVal("lt_exec", {3'b0, ex0}, 4'b1);
        12: checkVal("gt_exec", {3'b0, ex0}, 4'b0);
        13: checkVal("le_exec", {3'b0, ex0}, 4'b1);
        15: begin
          checkVal("nv_exec0", {3'b0, ex0}, 4'b0);
          checkVal("nv_exec1", {3'b0, ex1}, 4'b1);
        end
        default: ;
      endcase
    end

    // Block EQ, length 3, slot1 then / slot2 else, Z=1, with a bubble.
    loadFlags(4'b0100);
    clearInputs(); instrValid = 1; instrCond = 4'b0001; itStart = 1;
    itCond = 4'b0000; itLen = 3; itMask = 3'b001; applyStimulus();
    checkVal("it_open_exec", {3'b0, ex0}, 4'b1);
    checkVal("it_open_rem", {1'b0, rem0}, 4'd3);
    clearInputs(); instrValid = 1; instrCond = 4'b1111; applyStimulus();
    checkVal("slot0_exec", {3'b0, ex0}, 4'b1);
    clearInputs(); applyStimulus();
    checkVal("bubble_rem", {1'b0, rem0}, 4'd2);
    clearInputs(); instrValid = 1; applyStimulus();
    checkVal("slot1_exec", {3'b0, ex0}, 4'b1);
    clearInputs(); instrValid = 1; applyStimulus();
    checkVal("slot2_exec", {3'b0, ex0}, 4'b0);
    checkVal("slot2_active", {3'b0, act0}, 4'b0);

    // ADDS result N then MI; the same ADDS under a failing condition.
    loadFlags(4'b0000);
    clearInputs(); instrValid = 1; instrCond = 4'b1110; flagUpdate = 1;
    flagResult = 4'b1000; applyStimulus();
    clearInputs(); instrValid = 1; instrCond = 4'b0100; applyStimulus();
    checkVal("mi_after_adds", {3'b0, ex0}, 4'b1);
    loadFlags(4'b0000);
    clearInputs(); instrValid = 1; instrCond = 4'b0000; flagUpdate = 1;
    flagResult = 4'b1000; applyStimulus();
    checkVal("failed_adds_flags", fl0, 4'b0000);
    clearInputs(); instrValid = 1; instrCond = 4'b0100; applyStimulus();
    checkVal("mi_after_failed", {3'b0, ex0}, 4'b0);

    // Direct flag load wins over a simultaneous flag-setting instruction.
    clearInputs(); instrValid = 1; instrCond = 4'b1110; flagUpdate = 1;
    flagResult = 4'b0100; flagLoad = 1; flagLoadData = 4'b0011; applyStimulus();
    checkVal("load_priority", fl0, 4'b0011);

    // Flush mid-block, then reset mid-block.
    loadFlags(4'b1010);
    clearInputs(); instrValid = 1; itStart = 1; itCond = 4'b1110; itLen = 4;
    itMask = 3'b111; applyStimulus();
    clearInputs(); instrValid = 1; applyStimulus();
    clearInputs(); instrValid = 1; applyStimulus();
    checkVal("pre_flush_rem", {1'b0, rem0}, 4'd2);
    clearInputs(); instrValid = 1; flush = 1; flagUpdate = 1; flagResult = 4'b0101;
    applyStimulus();
    checkVal("flush_valid", {3'b0, ev0}, 4'b0);
    checkVal("flush_rem", {1'b0, rem0}, 4'd0);
    checkVal("flush_flags", fl0, 4'b1010);
    clearInputs(); instrValid = 1; itStart = 1; itCond = 4'b1110; itLen = 4;
    itMask = 3'b111; applyStimulus();
    clearInputs(); instrValid = 1; applyStimulus();
    clearInputs(); instrValid = 1; applyStimulus();
    clearInputs(); rst = 1; instrValid = 1; flagLoad = 1; flagLoadData = 4'b1111;
    applyStimulus();
    checkVal("reset_blk_flags", fl0, 4'b0000);
    checkVal("reset_blk_active", {3'b0, act0}, 4'b0);
    checkVal("reset_blk_exec", {3'b0, ex0}, 4'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      clearInputs();
      rst          = ($urandom_range(63) == 0);
      instrValid   = ($urandom_range(3) != 0);
      instrCond    = 4'($urandom);
      flagUpdate   = 1'($urandom);
      flagResult   = 4'($urandom);
      flagLoad     = ($urandom_range(7) == 0);
      flagLoadData = 4'($urandom);
      itStart      = ($urandom_range(3) == 0);
      itCond       = 4'($urandom);
      itMask       = 3'($urandom);
      itLen        = 3'($urandom);
      flush        = ($urandom_range(15) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_exec_ctrl.md
COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

Interface
REQ-001 SHALL have parameter IT_MAX_LEN, default 4, range 2..8, meaning the maximum number of instructions in one predicated block.
REQ-002 SHALL have parameter NV_EXEC, default 0, meaning: 0 = cond 1111 never executes; 1 = cond 1111 executes like AL.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port instr_valid_in, input, 1, an instruction is presented this cycle.
REQ-006 SHALL have port instr_cond_in, input, 4, the instruction condition field.
REQ-007 SHALL have port flag_update_in, input, 1, the instruction writes flags (S bit).
REQ-008 SHALL have port flag_result_in, input, 4, the ALU NZCV result for the presented instruction.
REQ-009 SHALL have port flag_load_in, input, 1, direct flag-register write (MSR path).
REQ-010 SHALL have port flag_load_data_in, input, 4, the value for the direct write.
REQ-011 SHALL have port it_start_in, input, 1, the presented instruction opens a predicated block.
REQ-012 SHALL have port it_cond_in, input, 4, the base condition of the block.
REQ-013 SHALL have port it_mask_in, input, IT_MAX_LEN-1, per-slot then/else bits (1 = then, 0 = else).
REQ-014 SHALL have port it_len_in, input, clog2(IT_MAX_LEN+1), the block length.
REQ-015 SHALL have port flush_in, input, 1, pipeline flush.
REQ-016 SHALL have port exec_valid_out, output, 1, exec_out is valid.
REQ-017 SHALL have port exec_out, output, 1, the instruction executes.
REQ-018 SHALL have port flag_register_out, output, 4, the current NZCV register ([3]=N, [2]=Z, [1]=C, [0]=V).
REQ-019 SHALL have port it_active_out, output, 1, the FSM is in state BLOCK.
REQ-020 SHALL have port it_remaining_out, output, clog2(IT_MAX_LEN+1), the number of block slots left.

Function
REQ-021 SHALL evaluate conditions against the registered flags: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 per NV_EXEC.
REQ-022 SHALL register exec_valid_out/exec_out one cycle after the instruction is presented (latency 1); exec_valid_out = instr_valid_in & !flush_in, delayed by one cycle.
REQ-023 SHALL have FSM states IDLE and BLOCK; in IDLE the evaluated condition is instr_cond_in.
REQ-024 SHALL, in IDLE with instr_valid_in & it_start_in & it_len_in!=0, give that instruction exec=1, not update the flags, go to BLOCK, load remaining=min(it_len_in, IT_MAX_LEN), and latch it_cond_in, it_mask_in and slot index 0.
REQ-025 SHALL treat it_start_in with it_len_in==0 as an ordinary instruction.
REQ-026 SHALL, in BLOCK, ignore instr_cond_in: slot 0 uses the latched cond; slot k>=1 uses the latched cond if mask[k-1]=1, else the cond with bit0 inverted; an else-slot with base AL evaluates to 0.
REQ-027 SHALL have each valid instruction in BLOCK consume one slot (index+1, remaining-1); remaining 1->0 returns the FSM to IDLE; instr_valid_in=0 holds the state.
REQ-028 SHALL ignore it_start_in in BLOCK; the instruction is evaluated as a normal slot.
REQ-029 SHALL update the flags at the clock edge: flag_load_in loads flag_load_data_in; else valid & executed & flag_update_in loads flag_result_in; else the flags hold.
REQ-030 SHALL make a flag update visible to the next presented instruction (no bypass within the same cycle).
REQ-031 SHALL, on flush_in, go to IDLE with remaining=0, suppress the flag update from the presented instruction, and drive exec_valid_out=0 next cycle; flag_load_in is still honoured.

Reset
REQ-032 SHALL, with reset_in high at a clock edge, set flags=0000, FSM=IDLE, remaining=0, slot index=0, exec_valid_out=0, exec_out=0, overriding all other inputs including an active block.

Verification
REQ-033 SHALL cover: flags 0100, cond EQ then NE -> exec_out 1 then 0, each one cycle after presentation.
REQ-034 SHALL cover: flags N=1,V=0,Z=0 over all 16 conds with NV_EXEC=0 -> GE 0, LT 1, GT 0, LE 1, 1111 gives 0; with NV_EXEC=1, 1111 gives 1.
REQ-035 SHALL cover: IT with cond EQ, len 3, mask 10, flags Z=1 -> slots give exec 1,1,0; it_active_out falls after the third valid slot; bubbles inside the block do not consume slots.
REQ-036 SHALL cover: an executed ADDS with result 1000 followed by MI -> exec 1; the same ADDS under a failed condition -> flags unchanged and MI gives 0.
REQ-037 SHALL cover: flag_load_in=1 with data 0011 together with an executed flag-setting instruction with result 0100 -> flags 0011.
REQ-038 SHALL cover: flush_in and then reset_in asserted mid-block (remaining 2) -> IDLE, remaining 0, exec_valid_out 0 next cycle; after reset, flags 0000.
